// File: rtl/count_stream_checker_pkg.sv
// Shared constants for the count stream checker: FSM encodings and default widths.
package count_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ROLL_W = 16;
    localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating event counter: sticks at all-ones, and a clear beats an increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_stream_checker.sv
// Watches a free-running upstream counter, locks onto its +1 sequence and
// reports breaks, wraps and the first offending value.
module count_stream_checker
    import count_stream_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ROLL_W = DEF_ROLL_W,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count_in_i,
    input  logic              count_valid_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              error_pulse_o,
    output logic              error_sticky_o,
    output logic [WIDTH-1:0]  bad_value_o,
    output logic [ROLL_W-1:0] rollover_count_o,
    output logic [ERR_W-1:0]  error_count_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] bad_value_q;
    logic             locked_q;
    logic             error_pulse_q;
    logic             error_sticky_q;

    logic [WIDTH-1:0] expected;
    logic             sample_match;
    logic             in_locked;
    logic             brk_hit;
    logic             roll_hit;

    assign expected     = prev_q + WIDTH'(1);
    assign sample_match = (count_in_i == expected);
    assign in_locked    = (state_q == ST_LOCKED);

    // A zero that is not the expected value is an upstream restart, not a break.
    assign brk_hit  = count_valid_i && in_locked && !sample_match && (count_in_i != '0);
    assign roll_hit = count_valid_i && in_locked && sample_match && (prev_q == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_ACQUIRE;
            prev_q         <= '0;
            bad_value_q    <= '0;
            locked_q       <= 1'b0;
            error_pulse_q  <= 1'b0;
            error_sticky_q <= 1'b0;
        end else begin
            error_pulse_q <= brk_hit;

            if (count_valid_i) begin
                prev_q <= count_in_i;
                case (state_q)
                    ST_ACQUIRE: begin
                        state_q  <= ST_CONFIRM;
                        locked_q <= 1'b0;
                    end
                    ST_CONFIRM, ST_LOCKED: begin
                        if (sample_match) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ST_CONFIRM;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= ST_ACQUIRE;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            // Only the first break since the last clear is recorded in bad_value.
            if (clear_i) begin
                error_sticky_q <= 1'b0;
                bad_value_q    <= '0;
            end else if (brk_hit) begin
                error_sticky_q <= 1'b1;
                if (!error_sticky_q) begin
                    bad_value_q <= count_in_i;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (ROLL_W)
    ) u_roll_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (roll_hit),
        .clr_i   (clear_i),
        .count_o (rollover_count_o)
    );

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (brk_hit),
        .clr_i   (clear_i),
        .count_o (error_count_o)
    );

    assign locked_o       = locked_q;
    assign error_pulse_o  = error_pulse_q;
    assign error_sticky_o = error_sticky_q;
    assign bad_value_o    = bad_value_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: lock, wrap, breaks, restart, gaps, saturation, clear and reset.
module tb_count_stream_checker;
    import count_stream_checker_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [DEF_WIDTH-1:0]  count_in_i;
    logic                  count_valid_i;
    logic                  clear_i;
    logic                  locked_o;
    logic                  error_pulse_o;
    logic                  error_sticky_o;
    logic [DEF_WIDTH-1:0]  bad_value_o;
    logic [DEF_ROLL_W-1:0] rollover_count_o;
    logic [DEF_ERR_W-1:0]  error_count_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    count_stream_checker #(
        .WIDTH  (DEF_WIDTH),
        .ROLL_W (DEF_ROLL_W),
        .ERR_W  (DEF_ERR_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .count_in_i       (count_in_i),
        .count_valid_i    (count_valid_i),
        .clear_i          (clear_i),
        .locked_o         (locked_o),
        .error_pulse_o    (error_pulse_o),
        .error_sticky_o   (error_sticky_o),
        .bad_value_o      (bad_value_o),
        .rollover_count_o (rollover_count_o),
        .error_count_o    (error_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns just after the edge that took them.
    task automatic send(input logic valid, input int value, input logic clr);
        @(negedge clk);
        count_valid_i = valid;
        count_in_i    = DEF_WIDTH'(value);
        clear_i       = clr;
        @(posedge clk);
        #1;
        count_valid_i = 1'b0;
        clear_i       = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        count_in_i    = '0;
        count_valid_i = 1'b0;
        clear_i       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_pulse", 32'(error_pulse_o), 0);
        chk("rst_sticky", 32'(error_sticky_o), 0);
        chk("rst_bad", 32'(bad_value_o), 0);
        chk("rst_roll", 32'(rollover_count_o), 0);
        chk("rst_err", 32'(error_count_o), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Acquire and lock on 0,1,2
        send(1'b1, 0, 1'b0);
        chk("acq_locked", 32'(locked_o), 0);
        send(1'b1, 1, 1'b0);
        chk("confirm_locked", 32'(locked_o), 1);
        send(1'b1, 2, 1'b0);
        chk("lock3_locked", 32'(locked_o), 1);
        chk("lock3_err", 32'(error_count_o), 0);

        // Run up to 254 and wrap
        for (int v = 3; v <= 254; v++) send(1'b1, v, 1'b0);
        send(1'b1, 255, 1'b0);
        chk("pre_wrap_roll", 32'(rollover_count_o), 0);
        send(1'b1, 0, 1'b0);
        chk("wrap_roll", 32'(rollover_count_o), 1);
        chk("wrap_pulse", 32'(error_pulse_o), 0);
        chk("wrap_locked", 32'(locked_o), 1);
        send(1'b1, 1, 1'b0);
        chk("post_wrap_pulse", 32'(error_pulse_o), 0);
        chk("post_wrap_err", 32'(error_count_o), 0);

        // Break at 40 after 10
        for (int v = 2; v <= 10; v++) send(1'b1, v, 1'b0);
        send(1'b1, 40, 1'b0);
        chk("brk1_pulse", 32'(error_pulse_o), 1);
        chk("brk1_sticky", 32'(error_sticky_o), 1);
        chk("brk1_bad", 32'(bad_value_o), 40);
        chk("brk1_locked", 32'(locked_o), 0);
        chk("brk1_err", 32'(error_count_o), 1);
        send(1'b1, 41, 1'b0);
        chk("brk1_pulse_drop", 32'(error_pulse_o), 0);
        send(1'b1, 42, 1'b0);
        chk("relock_locked", 32'(locked_o), 1);
        send(1'b1, 99, 1'b0);
        chk("brk2_pulse", 32'(error_pulse_o), 1);
        chk("brk2_bad_kept", 32'(bad_value_o), 40);
        chk("brk2_err", 32'(error_count_o), 2);

        // Upstream restart from 77
        send(1'b1, 100, 1'b0);
        send(1'b1, 0, 1'b0);
        chk("restart_a_locked", 32'(locked_o), 0);
        send(1'b1, 1, 1'b0);
        for (int v = 2; v <= 77; v++) send(1'b1, v, 1'b0);
        chk("at77_locked", 32'(locked_o), 1);
        send(1'b1, 0, 1'b0);
        chk("restart_locked", 32'(locked_o), 0);
        chk("restart_pulse", 32'(error_pulse_o), 0);
        chk("restart_err", 32'(error_count_o), 2);
        send(1'b1, 1, 1'b0);
        chk("restart_relock", 32'(locked_o), 1);

        // Five-cycle gap with garbage on count_in
        for (int i = 0; i < 5; i++) send(1'b0, int'($urandom_range(0, 255)), 1'b0);
        chk("gap_locked", 32'(locked_o), 1);
        chk("gap_err", 32'(error_count_o), 2);
        chk("gap_roll", 32'(rollover_count_o), 1);
        chk("gap_pulse", 32'(error_pulse_o), 0);
        send(1'b1, 2, 1'b0);
        chk("gap_resume_locked", 32'(locked_o), 1);
        chk("gap_resume_pulse", 32'(error_pulse_o), 0);

        // 300 more breaks saturate the error counter
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 10, 1'b0);
            send(1'b1, 11, 1'b0);
        end
        chk("sat_err", 32'(error_count_o), 255);
        chk("sat_sticky", 32'(error_sticky_o), 1);
        chk("sat_bad", 32'(bad_value_o), 40);
        chk("sat_locked", 32'(locked_o), 1);
        send(1'b1, 10, 1'b1);
        chk("clr_brk_err", 32'(error_count_o), 0);
        chk("clr_brk_sticky", 32'(error_sticky_o), 0);
        chk("clr_brk_pulse", 32'(error_pulse_o), 1);
        chk("clr_brk_bad", 32'(bad_value_o), 0);
        chk("clr_brk_locked", 32'(locked_o), 0);

        // Clear on the same edge as a wrap
        send(1'b1, 11, 1'b0);
        for (int v = 12; v <= 255; v++) send(1'b1, v, 1'b0);
        send(1'b1, 0, 1'b1);
        chk("clr_wrap_roll", 32'(rollover_count_o), 0);
        chk("clr_wrap_locked", 32'(locked_o), 1);

        // First break after a clear is captured again
        send(1'b1, 1, 1'b0);
        send(1'b1, 50, 1'b0);
        chk("post_clr_bad", 32'(bad_value_o), 50);
        chk("post_clr_err", 32'(error_count_o), 1);

        // Asynchronous reset between clock edges
        send(1'b1, 51, 1'b0);
        send(1'b1, 52, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked_o), 0);
        chk("async_err", 32'(error_count_o), 0);
        chk("async_sticky", 32'(error_sticky_o), 0);
        chk("async_bad", 32'(bad_value_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 7, 1'b0);
        chk("post_rst_acq", 32'(locked_o), 0);
        send(1'b1, 8, 1'b0);
        chk("post_rst_lock", 32'(locked_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/count_stream_checker.md
COUNT_STREAM_CHECKER -- requirements
Module: count_stream_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the monitored count.
REQ-002 SHALL have parameter ROLL_W, default 16, width of the rollover counter.
REQ-003 SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port count_in  input  WIDTH  count value produced by the upstream free-running counter.
REQ-007 SHALL have port count_valid  input  1  count_in is sampled only when high.
REQ-008 SHALL have port clear  input  1  synchronous clear of statistics and sticky error.
REQ-009 SHALL have port locked  output  1  checker is tracking a confirmed increment sequence.
REQ-010 SHALL have port error_pulse  output  1  one-cycle pulse per detected sequence break.
REQ-011 SHALL have port error_sticky  output  1  set on the first break and held until clear or reset.
REQ-012 SHALL have port bad_value  output  WIDTH  count_in value of the first break since the last clear or reset.
REQ-013 SHALL have port rollover_count  output  ROLL_W  saturating count of legal wraps from max to 0.
REQ-014 SHALL have port error_count  output  ERR_W  saturating count of breaks.

Function
REQ-015 SHALL hold a previous-sample register prev (WIDTH); expected = prev + 1, modulo 2^WIDTH.
REQ-016 SHALL implement FSM states ACQUIRE, CONFIRM and LOCKED; locked = 1 only in LOCKED.
REQ-017 ACQUIRE: on a valid sample, SHALL store it in prev and go to CONFIRM.
REQ-018 CONFIRM: on a valid sample equal to expected, SHALL go to LOCKED; otherwise SHALL stay in CONFIRM; SHALL flag no error in either case; SHALL update prev on every valid sample.
REQ-019 LOCKED, valid sample equal to expected: SHALL stay in LOCKED; if prev = 2^WIDTH-1 and the sample is 0, SHALL increment rollover_count.
REQ-020 LOCKED, valid sample of 0 when expected is not 0: SHALL treat it as an upstream restart, go to CONFIRM and flag no error.
REQ-021 LOCKED, any other mismatch: SHALL pulse error_pulse, increment error_count, set error_sticky, and go to CONFIRM.
REQ-022 On a mismatch under REQ-021, if error_sticky was 0, SHALL capture the sample into bad_value; later breaks SHALL NOT overwrite bad_value.
REQ-023 On a mismatch under REQ-021, SHALL store the sample in prev.
REQ-024 count_valid = 0: SHALL hold FSM state, prev and all statistics; a gap SHALL NOT be an error.
REQ-025 Latency: every output SHALL be registered and reflect a sample on the clock edge after that sample is taken.
REQ-026 rollover_count and error_count SHALL saturate at all-ones and never wrap.
REQ-027 clear: SHALL zero rollover_count, error_count, error_sticky and bad_value; SHALL NOT alter the FSM state or prev.
REQ-028 clear coinciding with a break: clear SHALL win for the counters, error_sticky and bad_value; error_pulse SHALL still assert.
REQ-029 clear coinciding with a rollover: rollover_count SHALL end at 0.

Reset
REQ-030 While reset = 0: FSM SHALL be in ACQUIRE; prev, bad_value, rollover_count and error_count SHALL be 0; locked, error_pulse and error_sticky SHALL be 0.
REQ-031 Reset SHALL take effect asynchronously and may assert mid-sequence; sampling SHALL resume on the first rising clock edge after reset returns to 1.

Structure
REQ-032 The FSM state encodings and the default widths SHALL live in a shared constants include used by this block and its bench.
REQ-033 Each statistic SHALL use one sub-module, sat_counter (parameter width, inputs inc and clr, saturating), instantiated twice.
REQ-034 RTL SHALL total 120-400 lines with no latches and no combinational output paths.

Verification
REQ-035 Reset, then count_in 0,1,2 valid on consecutive cycles -> locked = 1 after the third sample; error_count = 0.
REQ-036 Locked at 254, then 255, 0, 1 -> rollover_count = 1; no error_pulse.
REQ-037 Locked at 10, then inject 40 -> error_pulse for one cycle, error_sticky = 1, bad_value = 40, locked = 0; then 41, 42 -> relocked; then inject 99 -> bad_value stays 40 and error_count = 2.
REQ-038 Locked at 77, then 0 -> no error, state CONFIRM; then 1 -> locked = 1.
REQ-039 Hold count_valid = 0 for 5 cycles mid-sequence while count_in changes arbitrarily -> statistics and locked unchanged; the next valid sample is checked against the held prev.
REQ-040 Drive 300 breaks with ERR_W = 8 -> error_count = 255; assert clear in the same cycle as a break -> error_count = 0, error_sticky = 0, error_pulse = 1.
